// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared types and constants for the I2C write receiver.
package iic_pkg;

  localparam int IIC_ADDR_W = 7;
  localparam int IIC_BYTE_W = 8;
  localparam logic IIC_ACK = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } iic_state_e;

endpackage

// File: rtl/iic_line_sync.sv
// rtl/iic_line_sync.sv - pin synchronizer, optional 3-sample filter (IIC_SLAVE_GLITCH_FILTER_EN), edge pulses.
module iic_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   line_d;
  logic                   line_q;

  // Free-running so no stale edge is seen when reset releases mid-transfer.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    hist_q <= {hist_q[0], synced};
  end

  always_comb begin
    line_d = line_q;
    if ((synced == hist_q[0]) && (synced == hist_q[1])) begin
      line_d = synced;
    end
  end
`else
  always_comb begin
    line_d = synced;
  end
`endif

  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign level_o = line_q;
  assign rise_o  = line_d & ~line_q;
  assign fall_o  = ~line_d & line_q;

endmodule

// File: rtl/iic_slave_rx.sv
// rtl/iic_slave_rx.sv - I2C target write receiver with byte stream output.
// Glitch filtering on SCL/SDA is enabled by defining IIC_SLAVE_GLITCH_FILTER_EN.
module iic_slave_rx
  import iic_pkg::*;
#(
  parameter logic [IIC_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCL,
  input  logic                  SDA,
  output logic                  sda_oe,
  output logic                  tvalid,
  output logic [IIC_BYTE_W-1:0] tdata,
  input  logic                  tready,
  output logic                  start_det,
  output logic                  stop_det,
  output logic                  busy,
  output logic                  ovf
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_ev, stop_ev, pop;

  iic_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [IIC_BYTE_W-2:0] shift_q, shift_d;
  logic [IIC_BYTE_W-1:0] rx_byte;
  logic [IIC_BYTE_W-1:0] tdata_q, tdata_d;
  logic sda_oe_q, sda_oe_d;
  logic tvalid_q, tvalid_d;
  logic start_det_q, start_det_d;
  logic stop_det_q, stop_det_d;
  logic busy_q, busy_d;
  logic ovf_q, ovf_d;
  logic ack_en_q, ack_en_d;
  logic ack_fall_q, ack_fall_d;

  iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk    (clk),
    .line_i (SCL),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk    (clk),
    .line_i (SDA),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;
  assign pop      = tvalid_q & tready;
  assign rx_byte  = {shift_q, sda_lvl};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tdata_d     = tdata_q;
    sda_oe_d    = sda_oe_q;
    tvalid_d    = tvalid_q & ~pop;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    ack_en_d    = ack_en_q;
    ack_fall_d  = ack_fall_q;

    if (stop_ev) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
      ack_fall_d = 1'b0;
    end else if (start_ev) begin
      state_d     = ADDR;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      start_det_d = 1'b1;
      ack_fall_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte[IIC_BYTE_W-2:0];
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d  = 3'd0;
              ack_fall_d = 1'b0;
              if ((rx_byte[IIC_BYTE_W-1:1] == SLAVE_ADDR) && !rx_byte[0]) begin
                state_d  = ADDR_ACK;
                busy_d   = 1'b1;
                ack_en_d = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        // First SCL fall after the 8th bit drives the ACK, the next one releases it.
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_fall_q) begin
              ack_fall_d = 1'b1;
              sda_oe_d   = ack_en_q & (IIC_ACK == 1'b0);
            end else begin
              ack_fall_d = 1'b0;
              sda_oe_d   = 1'b0;
              state_d    = DATA;
              bit_cnt_d  = 3'd0;
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte[IIC_BYTE_W-2:0];
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d  = 3'd0;
              ack_fall_d = 1'b0;
              state_d    = DATA_ACK;
              if (!tvalid_q || pop) begin
                tvalid_d = 1'b1;
                tdata_d  = rx_byte;
                ack_en_d = 1'b1;
              end else begin
                ovf_d    = 1'b1;
                ack_en_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      tdata_q     <= '0;
      sda_oe_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ack_en_q    <= 1'b0;
      ack_fall_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tdata_q     <= tdata_d;
      sda_oe_q    <= sda_oe_d;
      tvalid_q    <= tvalid_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      ack_en_q    <= ack_en_d;
      ack_fall_q  <= ack_fall_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign tvalid    = tvalid_q;
  assign tdata     = tdata_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_iic_slave_rx.sv
// tb/tb_iic_slave_rx.sv - directed bench: bus master model driving iic_slave_rx.
module tb_iic_slave_rx;
  import iic_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       tready = 1'b1;
  logic       sda_bus;
  logic       sda_oe, tvalid, start_det, stop_det, busy, ovf;
  logic [7:0] tdata;

  int         vec_cnt = 0;
  int         miscompare_cnt = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         rx_wr = 0;
  logic [7:0] rx_mem [64];

  assign sda_bus = sda_m & ~sda_oe;

  iic_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .SCL      (scl_m),
    .SDA      (sda_bus),
    .sda_oe   (sda_oe),
    .tvalid   (tvalid),
    .tdata    (tdata),
    .tready   (tready),
    .start_det(start_det),
    .stop_det (stop_det),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && tready) begin
        rx_mem[rx_wr % 64] = tdata;
        rx_wr = rx_wr + 1;
      end
      if (start_det) start_cnt = start_cnt + 1;
      if (stop_det) stop_cnt = stop_cnt + 1;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = sda_bus;
    wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  initial begin
    logic ack;
    int s0, p0, r0;

    repeat (12) @(negedge clk);
    check_vec("rst_sda_oe", sda_oe, 0);
    check_vec("rst_tvalid", tvalid, 0);
    check_vec("rst_tdata", tdata, 8'h00);
    check_vec("rst_start_det", start_det, 0);
    check_vec("rst_stop_det", stop_det, 0);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_ovf", ovf, 0);
    rst = 1'b0;
    wait_q();

    // Plain write: address 0x50, two data bytes, consumer always ready.
    s0 = start_cnt; p0 = stop_cnt; r0 = rx_wr;
    bus_start();
    send_byte(8'hA0, ack); check_vec("wr_addr_ack", ack, 0);
    check_vec("wr_busy", busy, 1);
    send_byte(8'h3C, ack); check_vec("wr_d0_ack", ack, 0);
    send_byte(8'hC3, ack); check_vec("wr_d1_ack", ack, 0);
    bus_stop(); wait_q();
    check_vec("wr_busy_end", busy, 0);
    check_vec("wr_rx_cnt", rx_wr - r0, 2);
    check_vec("wr_rx0", rx_mem[r0 % 64], 8'h3C);
    check_vec("wr_rx1", rx_mem[(r0 + 1) % 64], 8'hC3);
    check_vec("wr_starts", start_cnt - s0, 1);
    check_vec("wr_stops", stop_cnt - p0, 1);

    // Wrong address.
    r0 = rx_wr;
    bus_start();
    send_byte(8'hA2, ack); check_vec("badaddr_nack", ack, 1);
    check_vec("badaddr_busy", busy, 0);
    send_byte(8'h55, ack); check_vec("badaddr_data_nack", ack, 1);
    check_vec("badaddr_state", dut.state_q, IGNORE);
    bus_stop(); wait_q();
    check_vec("badaddr_rx_cnt", rx_wr - r0, 0);

    // Read request to our address.
    r0 = rx_wr;
    bus_start();
    send_byte(8'hA1, ack); check_vec("read_nack", ack, 1);
    check_vec("read_state", dut.state_q, IGNORE);
    bus_stop(); wait_q();
    check_vec("read_rx_cnt", rx_wr - r0, 0);

    // Consumer stalled: second byte overflows.
    tready = 1'b0;
    r0 = rx_wr;
    bus_start();
    send_byte(8'hA0, ack); check_vec("ovf_addr_ack", ack, 0);
    send_byte(8'h11, ack); check_vec("ovf_d0_ack", ack, 0);
    send_byte(8'h22, ack); check_vec("ovf_d1_nack", ack, 1);
    check_vec("ovf_flag", ovf, 1);
    check_vec("ovf_tvalid", tvalid, 1);
    check_vec("ovf_tdata", tdata, 8'h11);
    bus_stop(); wait_q();
    check_vec("ovf_rx_none", rx_wr - r0, 0);
    tready = 1'b1;
    repeat (3) @(negedge clk);
    check_vec("ovf_rx_cnt", rx_wr - r0, 1);
    check_vec("ovf_rx0", rx_mem[r0 % 64], 8'h11);
    check_vec("ovf_tvalid_clr", tvalid, 0);

    // Repeated START after 4 data bits.
    s0 = start_cnt; r0 = rx_wr;
    bus_start();
    send_byte(8'hA0, ack); check_vec("rs_addr_ack", ack, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_start();
    send_byte(8'hA0, ack); check_vec("rs_addr2_ack", ack, 0);
    send_byte(8'h5A, ack); check_vec("rs_data_ack", ack, 0);
    bus_stop(); wait_q();
    check_vec("rs_starts", start_cnt - s0, 2);
    check_vec("rs_rx_cnt", rx_wr - r0, 1);
    check_vec("rs_rx0", rx_mem[r0 % 64], 8'h5A);
    check_vec("rs_ovf_sticky", ovf, 1);

    // Reset while the slave holds SDA low for an address ACK.
    r0 = rx_wr;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hA0 >> i) & 1) != 0);
    sda_m = 1'b1; wait_q();
    check_vec("rstack_oe_before", sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check_vec("rstack_oe_after", sda_oe, 0);
    check_vec("rstack_ovf_clr", ovf, 0);
    rst = 1'b0;
    scl_m = 1'b1; wait_q(); scl_m = 1'b0; wait_q();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check_vec("rstack_oe_idle", sda_oe, 0);
    check_vec("rstack_busy", busy, 0);
    bus_start();
    send_byte(8'hA0, ack); check_vec("rstack_addr_ack", ack, 0);
    send_byte(8'h77, ack); check_vec("rstack_data_ack", ack, 0);
    bus_stop(); wait_q();
    check_vec("rstack_rx_cnt", rx_wr - r0, 1);
    check_vec("rstack_rx0", rx_mem[r0 % 64], 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule

// File: doc/iic_slave_rx.md
# iic_slave_rx

I2C target-side write receiver and the counterpart of the team's I2C master transmitter on the same two-wire bus. It oversamples SCL/SDA in the system clock domain, detects START/STOP, matches a 7-bit address, and acknowledges write transfers. It delivers each received data byte on a valid/ready stream with a one-byte holding register. It sits between the board-level SCL/SDA pins (open-drain, SDA pulled low via `sda_oe`) and the internal configuration logic.

## Interface
- `SLAVE_ADDR`, 7'h50: 7-bit address this block answers to.
- `SYNC_STAGES`, 2: synchronizer depth for SCL and SDA; legal range ≥ 2.
- `clk` input 1: system clock; must be ≥ 8× the SCL rate.
- `rst` input 1: synchronous, active-high reset.
- `SCL` input 1: bus clock from the pin; asynchronous.
- `SDA` input 1: bus data from the pin; asynchronous.
- `sda_oe` output 1: 1 drives SDA low (ACK); 0 releases.
- `tvalid` output 1: received data byte available.
- `tdata` output 8: received data byte.
- `tready` input 1: consumer accepts byte when `tvalid & tready`.
- `start_det` output 1: one-cycle pulse on START or repeated START.
- `stop_det` output 1: one-cycle pulse on STOP.
- `busy` output 1: high from addressed START until STOP.
- `ovf` output 1: sticky; set when a byte is NACKed because the holding register is full; cleared only by `rst`.

## Operation
- SCL/SDA pass through `SYNC_STAGES` flops, then one more register (`scl_q`, `sda_q`) for edge detection. All events are derived from the synced values only.
- START: `sda_q` falls while `scl_q` high. STOP: `sda_q` rises while `scl_q` high. Both are detected in every state, including during reset release.
- States:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits MSB-first on SCL rising edges.
  - ADDR_ACK
  - DATA: shifts 8 bits.
  - DATA_ACK
  - IGNORE: waits for STOP or START.
- START in any state → ADDR, with the bit counter cleared, `sda_oe`=0, and `start_det` pulsed.
- STOP in any state → IDLE, with `sda_oe`=0, `busy`=0, and `stop_det` pulsed.
- ADDR, after 8th bit:
  - If addr[7:1]==`SLAVE_ADDR` and R/W=0 → ADDR_ACK, `busy`=1.
  - Otherwise (mismatch or read request) → IGNORE, no ACK.
- ADDR_ACK / DATA_ACK:
  - `sda_oe` asserts on the first SCL falling edge after the 8th rising edge.
  - It deasserts on the next SCL falling edge (the 9th falling edge).
  - The state then moves to DATA.
- DATA, after 8th bit:
  - If the holding register is empty, or is being emptied that same cycle (`tvalid & tready`): load the byte, assert `tvalid`, go to DATA_ACK.
  - Otherwise: drop the byte, set `ovf`, and give no ACK (NACK). The state still moves to DATA_ACK, but `sda_oe` stays 0.
- `tvalid` clears on `tvalid & tready`. `tdata` is held stable while `tvalid`=1.
- A STOP or START arriving mid-byte discards the partial byte. A byte already in the holding register is kept.

## Timing
- Reset values: `sda_oe`=0, `tvalid`=0, `tdata`=8'h00, `start_det`=0, `stop_det`=0, `busy`=0, `ovf`=0, state=IDLE, bit counter=0, shift register=0.
- After reset the block ignores the bus until the next START, even if reset lands mid-transfer.
- Pin-to-event latency: `SYNC_STAGES`+1 cycles; +2 with the glitch filter.
- `tvalid` rises 1 cycle after the internal SCL rising-edge event that samples bit 0 (the LSB).
- `start_det` and `stop_det` assert 1 cycle after the internal SDA edge event.
- Handshake: `tvalid` never drops without `tready`. Back-to-back bytes are accepted without gaps, provided `tready` is high before the next 8th bit.

## Configuration
- `IIC_SLAVE_GLITCH_FILTER_EN` defined: synced SCL and SDA each pass a 3-sample filter. The output changes only after 3 consecutive equal samples, which rejects pulses shorter than 3 `clk` cycles and adds 2 cycles latency.
- Undefined: synced values feed edge detection directly.

## Structure
- Package `iic_pkg`: state enum (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE), `IIC_ADDR_W`=7, `IIC_BYTE_W`=8, `IIC_ACK`=1'b0.
- Sub-module `iic_line_sync`: synchronizer, optional glitch filter, and edge-pulse generation; instantiated once per line.

## Test plan
- Write to 0x50 (addr byte 8'hA0), data 8'h3C, 8'hC3, `tready`=1 → ACK on all 3 bytes; two `tvalid` pulses carrying 8'h3C then 8'hC3; `stop_det` pulsed; `busy` back to 0.
- Address byte 8'hA2 (addr 0x51) → no ACK; no `tvalid`; state IGNORE until STOP.
- Address byte 8'hA1 (read to 0x50) → NACK; no `tvalid`; IGNORE.
- `tready`=0, write 8'h11 then 8'h22 → 8'h11 ACKed and held; 8'h22 NACKed; `ovf`=1; `tdata` stays 8'h11.
- Repeated START after 4 data bits, then a fresh write of 8'h5A → partial byte discarded; `start_det` pulsed twice; only 8'h5A delivered.
- `rst` asserted mid-byte with SDA held by ACK → `sda_oe`=0 next cycle; remaining bits ignored; next START + 8'hA0 + 8'h77 → delivers 8'h77.
